// File: rtl/seq_det_sched_if.sv
// Requester and result handshake bundle for the shared serial pattern-detector scheduler.
// The master side is the requester/consumer side; the slave side is the scheduler.
interface seq_det_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(WIDTH + 1);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [IDW-1:0]        res_id;
    logic [CW-1:0]         res_count;
    logic                  res_hit;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_id, res_count, res_hit
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_id, res_count, res_hit
    );
endinterface

// File: rtl/seq_det_sched.sv
// Round-robin job scheduler feeding one programmable sliding-window bit-pattern detector.
// Each granted word is shifted MSB-first; the per-job match count is returned tagged with its requester.
module seq_det_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_cfg_pat,
    input  logic [3:0]  i_cfg_len,
    input  logic        i_cfg_ovl,
    output logic        o_busy,
    seq_det_sched_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_grant;
    logic [WIDTH-1:0] r_word;
    logic [7:0]       r_pat;
    logic [3:0]       r_len;
    logic             r_ovl;
    logic [6:0]       r_hist;
    logic [3:0]       r_fill;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_bits_left;
    logic             r_hit;
    logic             r_res_valid;

    logic             w_any;
    logic [IDW-1:0]   w_grant;
    logic [NREQ-1:0]  w_ready;
    logic             w_bit;
    logic [7:0]       w_hist_new;
    logic [3:0]       w_fill_new;
    logic [7:0]       w_mask;
    logic             w_len_ok;
    logic             w_match;

    // Search from rr_ptr upward with wrap; descending loop lets the nearest valid requester win.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_any   = 1'b0;
        w_grant = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_any   = 1'b1;
                w_grant = IDW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (!i_rst && r_state == S_IDLE && w_any)
            w_ready[w_grant] = 1'b1;
    end

    assign w_bit      = r_word[WIDTH-1];
    assign w_hist_new = {r_hist, w_bit};
    assign w_fill_new = (r_fill == 4'd8) ? 4'd8 : r_fill + 4'd1;
    assign w_len_ok   = (r_len != 4'd0) && (r_len <= 4'd8);
    assign w_mask     = 8'hFF >> (4'd8 - r_len);
    assign w_match    = w_len_ok && (w_fill_new >= r_len)
                        && ((w_hist_new & w_mask) == (r_pat & w_mask));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_word      <= '0;
            r_pat       <= '0;
            r_len       <= '0;
            r_ovl       <= 1'b0;
            r_hist      <= '0;
            r_fill      <= '0;
            r_count     <= '0;
            r_bits_left <= '0;
            r_hit       <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_grant;
                        r_word      <= bus.req_data[int'(w_grant)*WIDTH +: WIDTH];
                        r_pat       <= i_cfg_pat;
                        r_len       <= i_cfg_len;
                        r_ovl       <= i_cfg_ovl;
                        r_hist      <= '0;
                        r_fill      <= '0;
                        r_count     <= '0;
                        r_hit       <= 1'b0;
                        r_bits_left <= CW'(WIDTH);
                        r_state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_word      <= {r_word[WIDTH-2:0], 1'b0};
                    r_hist      <= w_hist_new[6:0];
                    r_bits_left <= r_bits_left - CW'(1);
                    if (w_match) begin
                        r_count <= r_count + CW'(1);
                        r_hit   <= 1'b1;
                        // Non-overlapping mode restarts the window so the next match needs L fresh bits.
                        r_fill  <= r_ovl ? w_fill_new : 4'd0;
                    end else begin
                        r_fill  <= w_fill_new;
                    end
                    if (r_bits_left == CW'(1)) begin
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_rr_ptr    <= (r_grant == IDW'(NREQ - 1)) ? '0 : r_grant + IDW'(1);
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_id    = r_grant;
    assign bus.res_count = r_count;
    assign bus.res_hit   = r_hit;
    assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed plus randomized bench for seq_det_sched; expected results come from a bit-list
// pattern scan and a round-robin pointer model kept here.
module tb_seq_det_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int CW    = $clog2(WIDTH + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cfg_pat;
    logic [3:0] cfg_len;
    logic       cfg_ovl;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int               exp_ptr;
    int               job_id;
    logic [WIDTH-1:0] job_word;
    logic [7:0]       job_pat;
    int               job_len;
    bit               job_ovl;
    int               acc_cyc;
    int               prev_acc;
    logic [WIDTH-1:0] data_w [NREQ];

    seq_det_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    seq_det_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_cfg_pat (cfg_pat),
        .i_cfg_len (cfg_len),
        .i_cfg_ovl (cfg_ovl),
        .o_busy    (busy),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count pattern occurrences in the bit stream, oldest pattern bit first.
    function automatic int ref_count(logic [WIDTH-1:0] w, logic [7:0] p, int len, bit ovl);
        bit s [WIDTH];
        int cnt   = 0;
        int start = 0;
        bit ok;
        if (len < 1 || len > 8) return 0;
        for (int i = 0; i < WIDTH; i++) s[i] = w[WIDTH-1-i];
        for (int i = 0; i < WIDTH; i++) begin
            if (i - start + 1 >= len) begin
                ok = 1'b1;
                for (int j = 0; j < len; j++)
                    if (s[i-j] != p[j]) ok = 1'b0;
                if (ok) begin
                    cnt++;
                    if (!ovl) start = i + 1;
                end
            end
        end
        return cnt;
    endfunction

    function automatic int exp_grant(logic [NREQ-1:0] m);
        for (int k = 0; k < NREQ; k++)
            if (m[(exp_ptr + k) % NREQ]) return (exp_ptr + k) % NREQ;
        return 0;
    endfunction

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = data_w[i];
    endtask

    // Called in IDLE, just after a rising edge; returns just after the acceptance edge.
    task automatic accept(input logic [NREQ-1:0] vmask, input bit keep, input string tag);
        int g;
        logic [NREQ-1:0] oh;
        bus.req_valid = vmask;
        drive_data();
        #1;
        g = exp_grant(vmask);
        oh = '0;
        oh[g] = 1'b1;
        check($sformatf("%s/req_ready", tag), bus.req_ready, oh);
        job_id   = g;
        job_word = data_w[g];
        job_pat  = cfg_pat;
        job_len  = cfg_len;
        job_ovl  = cfg_ovl;
        acc_cyc  = cyc;
        bus.res_ready = 1'b0;
        @(posedge clk); #1;
        data_w[g] = WIDTH'($urandom);
        bus.req_valid = keep ? vmask : '0;
        drive_data();
        check($sformatf("%s/busy_shift", tag), busy, 1);
        check($sformatf("%s/ready_shift", tag), bus.req_ready, 0);
    endtask

    task automatic finish(input int hold, input string tag);
        int n = 0;
        int ec;
        while (bus.res_valid !== 1'b1 && n < 4*WIDTH) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("%s/latency", tag), n, WIDTH);
        ec = ref_count(job_word, job_pat, job_len, job_ovl);
        check($sformatf("%s/res_id", tag), bus.res_id, job_id);
        check($sformatf("%s/res_count", tag), bus.res_count, ec);
        check($sformatf("%s/res_hit", tag), bus.res_hit, ec != 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s/hold_valid", tag), bus.res_valid, 1);
            check($sformatf("%s/hold_count", tag), bus.res_count, ec);
            check($sformatf("%s/hold_id", tag), bus.res_id, job_id);
            check($sformatf("%s/hold_ready", tag), bus.req_ready, 0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        check($sformatf("%s/released_valid", tag), bus.res_valid, 0);
        check($sformatf("%s/released_busy", tag), busy, 0);
        exp_ptr = (job_id + 1) % NREQ;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.res_ready = 1'b0;
        cfg_pat = 8'h0B;
        cfg_len = 4'd4;
        cfg_ovl = 1'b1;
        for (int i = 0; i < NREQ; i++) data_w[i] = '0;
        exp_ptr = 0;

        // Reset values, with requests pending so req_ready must stay low.
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid = '1;
        #1;
        check("rst/req_ready", bus.req_ready, 0);
        check("rst/res_valid", bus.res_valid, 0);
        check("rst/res_id", bus.res_id, 0);
        check("rst/res_count", bus.res_count, 0);
        check("rst/res_hit", bus.res_hit, 0);
        check("rst/busy", busy, 0);
        bus.req_valid = '0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic 1011 match.
        data_w[0] = 16'hB000;
        accept(4'b0001, 1'b0, "basic");
        finish(0, "basic");

        // Overlapping versus non-overlapping on the same word.
        data_w[0] = 16'hB6C0;
        accept(4'b0001, 1'b0, "ovl1");
        finish(0, "ovl1");
        cfg_ovl = 1'b0;
        data_w[0] = 16'hB6C0;
        accept(4'b0001, 1'b0, "ovl0");
        finish(0, "ovl0");

        // Length edge cases.
        cfg_len = 4'd0;
        data_w[2] = 16'hFFFF;
        accept(4'b0100, 1'b0, "len0");
        finish(0, "len0");
        cfg_len = 4'd1; cfg_pat = 8'h01; cfg_ovl = 1'b1;
        data_w[1] = 16'hFFFF;
        accept(4'b0010, 1'b0, "len1");
        finish(0, "len1");
        cfg_len = 4'd12;
        data_w[3] = 16'hFFFF;
        accept(4'b1000, 1'b0, "len12");
        finish(0, "len12");

        // Config changed while the job is shifting.
        cfg_pat = 8'h0B; cfg_len = 4'd4; cfg_ovl = 1'b1;
        data_w[0] = 16'hB6C0;
        accept(4'b0001, 1'b0, "cfgchg");
        cfg_pat = 8'hFF; cfg_len = 4'd2; cfg_ovl = 1'b0;
        finish(0, "cfgchg");

        // Backpressure with every requester waiting.
        cfg_pat = 8'h05; cfg_len = 4'd3; cfg_ovl = 1'b1;
        for (int i = 0; i < NREQ; i++) data_w[i] = WIDTH'($urandom);
        accept('1, 1'b1, "bp");
        finish(10, "bp");
        bus.req_valid = '0;

        // Randomized jobs.
        for (int t = 0; t < 24; t++) begin
            cfg_pat = 8'($urandom);
            cfg_len = 4'($urandom_range(0, 9));
            cfg_ovl = 1'($urandom_range(0, 1));
            for (int i = 0; i < NREQ; i++) data_w[i] = WIDTH'($urandom);
            accept(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'($urandom_range(0, 1)),
                   $sformatf("rnd%0d", t));
            finish($urandom_range(0, 3), $sformatf("rnd%0d", t));
        end

        // Reset in the middle of SHIFT.
        cfg_pat = 8'h03; cfg_len = 4'd2; cfg_ovl = 1'b1;
        data_w[exp_grant('1)] = 16'hFFFF;
        accept('1, 1'b1, "midrst");
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("midrst/res_valid", bus.res_valid, 0);
        check("midrst/res_count", bus.res_count, 0);
        check("midrst/res_hit", bus.res_hit, 0);
        check("midrst/res_id", bus.res_id, 0);
        check("midrst/busy", busy, 0);
        check("midrst/req_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        check("midrst/held_ready", bus.req_ready, 0);
        rst = 1'b0;
        exp_ptr = 0;

        // Round-robin fairness from a fresh pointer: 0,1,2,3,0 spaced WIDTH+2 apart.
        for (int k = 0; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) data_w[i] = WIDTH'($urandom);
            prev_acc = acc_cyc;
            accept('1, 1'b1, $sformatf("fair%0d", k));
            check($sformatf("fair%0d/grant", k), job_id, k % NREQ);
            if (k > 0) check($sformatf("fair%0d/spacing", k), acc_cyc - prev_acc, WIDTH + 2);
            finish(0, $sformatf("fair%0d", k));
        end
        bus.req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
